// File: rtl/dtree_feature_feeder.sv
// Buffers one spike feature vector and replays it to the dtree classifier,
// one pass per tree level, until the classifier completes or MAX_PASSES runs out.
// Ports: clk, reset (sync, active-high); s_valid/s_data/s_ready upstream words;
// dt_ready/dt_valid/dt_sample to dtree; dt_out_valid from dtree;
// vec_done/vec_timeout pulses; err_spurious sticky.
// Build option: DTREE_FEEDER_DOUBLE_BUF_EN selects ping-pong buffering.
module dtree_feature_feeder #(
  parameter int FEATURES   = 3,
  parameter int IN_WIDTH   = 10,
  parameter int MAX_PASSES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  input  logic [IN_WIDTH-1:0] s_data,
  output logic                s_ready,
  input  logic                dt_ready,
  output logic                dt_valid,
  output logic [IN_WIDTH-1:0] dt_sample,
  input  logic                dt_out_valid,
  output logic                vec_done,
  output logic                vec_timeout,
  output logic                err_spurious
);

`ifdef DTREE_FEEDER_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  localparam int IW = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int PW = $clog2(MAX_PASSES + 1);
  localparam logic [IW-1:0] LAST = IW'(FEATURES - 1);
  localparam logic [PW-1:0] MAXP = PW'(MAX_PASSES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REPLAY,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [IN_WIDTH-1:0] r_buf [2][FEATURES];
  logic [1:0]          r_full;
  logic                r_wsel;
  logic                r_rsel;
  logic [IW-1:0]       r_widx;
  logic [IW-1:0]       r_ridx;
  logic [IW-1:0]       w_ridx_nx;
  logic [PW-1:0]       r_pass;
  logic [PW-1:0]       w_pass_nx;
  logic [IN_WIDTH-1:0] r_dt_sample;
  logic                r_dt_valid;
  logic                r_vec_done;
  logic                r_vec_timeout;
  logic                r_err;

  logic w_load;
  logic w_load_last;
  logic w_xfer;
  logic w_act_rdy;
  logic w_pending;
  logic w_free;
  logic w_done;
  logic w_tmo;

  // In single-buffer mode both selects stay at 0, so buffer 1 is never used.
  assign s_ready     = !reset && !r_full[r_wsel];
  assign w_load      = s_valid && s_ready;
  assign w_load_last = w_load && (r_widx == LAST);
  assign w_xfer      = (r_state == S_REPLAY) && dt_ready;

  // A load completing this cycle counts, so replay starts the next cycle.
  assign w_act_rdy = r_full[r_rsel] ||
                     (w_load_last && (r_wsel == r_rsel));
  assign w_pending = DB && (r_full[~r_rsel] ||
                     (w_load_last && (r_wsel != r_rsel)));

  always_comb begin
    w_state_nx = r_state;
    w_ridx_nx  = r_ridx;
    w_pass_nx  = r_pass;
    w_free     = 1'b0;
    w_done     = 1'b0;
    w_tmo      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_act_rdy) begin
          w_state_nx = S_REPLAY;
          w_ridx_nx  = '0;
          w_pass_nx  = '0;
        end
      end
      S_REPLAY: begin
        if (dt_out_valid) begin
          w_free     = 1'b1;
          w_done     = 1'b1;
          w_ridx_nx  = '0;
          w_pass_nx  = '0;
          w_state_nx = w_pending ? S_GAP : S_IDLE;
        end else if (w_xfer) begin
          if (r_ridx == LAST) begin
            w_ridx_nx = '0;
            if ((r_pass + PW'(1)) >= MAXP) begin
              w_free     = 1'b1;
              w_tmo      = 1'b1;
              w_pass_nx  = '0;
              w_state_nx = w_pending ? S_GAP : S_IDLE;
            end else begin
              w_pass_nx  = r_pass + PW'(1);
              w_state_nx = S_GAP;
            end
          end else begin
            w_ridx_nx = r_ridx + IW'(1);
          end
        end
      end
      S_GAP: begin
        if (dt_out_valid) begin
          w_free     = 1'b1;
          w_done     = 1'b1;
          w_ridx_nx  = '0;
          w_pass_nx  = '0;
          w_state_nx = w_pending ? S_GAP : S_IDLE;
        end else begin
          w_state_nx = S_REPLAY;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_buf[r_wsel][r_widx] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_full        <= '0;
      r_wsel        <= 1'b0;
      r_rsel        <= 1'b0;
      r_widx        <= '0;
      r_ridx        <= '0;
      r_pass        <= '0;
      r_dt_valid    <= 1'b0;
      r_dt_sample   <= '0;
      r_vec_done    <= 1'b0;
      r_vec_timeout <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ridx  <= w_ridx_nx;
      r_pass  <= w_pass_nx;
      if (w_load) begin
        r_widx <= w_load_last ? '0 : r_widx + IW'(1);
      end
      if (w_load_last && DB) begin
        r_wsel <= ~r_wsel;
      end
      if (w_free && DB) begin
        r_rsel <= ~r_rsel;
      end
      for (int b = 0; b < 2; b++) begin
        r_full[b] <= (r_full[b] | (w_load_last && (r_wsel == 1'(b))))
                   & ~(w_free && (r_rsel == 1'(b)));
      end
      // Replay never resumes in the same cycle as a free, so r_rsel is current.
      r_dt_valid <= (w_state_nx == S_REPLAY);
      if (w_state_nx == S_REPLAY) begin
        r_dt_sample <= r_buf[r_rsel][w_ridx_nx];
      end
      r_vec_done    <= w_done;
      r_vec_timeout <= w_tmo;
      if ((r_state == S_IDLE) && dt_out_valid) begin
        r_err <= 1'b1;
      end
    end
  end

  assign dt_valid     = r_dt_valid;
  assign dt_sample    = r_dt_sample;
  assign vec_done     = r_vec_done;
  assign vec_timeout  = r_vec_timeout;
  assign err_spurious = r_err;

endmodule

// File: doc/dtree_feature_feeder.md
# dtree_feature_feeder

Buffers one spike feature vector (FEATURES words) arriving from the upstream feature-extraction stage and replays it to the `dtree` classifier. The classifier consumes one full vector per tree level. It signals completion with `out_valid` (the `dt_out_valid` input here), after which the feeder releases the vector and presents the next one. The block sits directly upstream of `dtree`, between the feature extractor and the classifier's `ready/in_valid/sample` port.

## Interface

Parameters:
- `FEATURES`, 3, words per feature vector; must be ≥2.
- `IN_WIDTH`, 10, feature word width.
- `MAX_PASSES`, 4, maximum replays of one vector before it is dropped; must be ≥1.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  upstream feature word valid.
- `s_data`  in  IN_WIDTH  upstream feature word; index order 0..FEATURES-1.
- `s_ready`  out  1  feeder can accept a word.
- `dt_ready`  in  1  `dtree` ready for a sample.
- `dt_valid`  out  1  `dt_sample` valid.
- `dt_sample`  out  IN_WIDTH  replayed feature word.
- `dt_out_valid`  in  1  `dtree` classification complete.
- `vec_done`  out  1  one-cycle pulse: vector retired by `dt_out_valid`.
- `vec_timeout`  out  1  one-cycle pulse: vector dropped after MAX_PASSES passes.
- `err_spurious`  out  1  sticky: `dt_out_valid` seen with no active vector.

## Operation

- **Load.** A word transfers when `s_valid && s_ready` and is written to the load buffer at write index `widx` (0..FEATURES-1). `widx` wraps to 0 after FEATURES-1, and that buffer is then marked full.
- **Replay states.** Replay uses these states: IDLE, REPLAY, GAP.
  - IDLE → REPLAY when the active buffer is full.
  - In REPLAY, `dt_valid`=1 and `dt_sample`=buf[`ridx`]. `ridx` advances only on `dt_valid && dt_ready`. Holding `dt_ready` low stalls replay indefinitely, with `dt_valid` and `dt_sample` held.
  - A transfer at `ridx`=FEATURES-1 ends a pass. The FSM goes to GAP, sets `ridx` to 0 and increments `pass_cnt`.
  - GAP lasts one cycle with `dt_valid`=0, then returns to REPLAY.
  - If `pass_cnt` has reached MAX_PASSES at GAP entry, the vector is freed and `vec_timeout` pulses. The FSM then goes to IDLE, or to GAP-then-REPLAY if another buffer is full.
- **Retire on `dt_out_valid`.**
  - When sampled high in REPLAY or GAP, the current pass is aborted and the active buffer freed.
  - `pass_cnt` and `ridx` are cleared, `vec_done` pulses and the FSM enters GAP, or IDLE if no vector is pending.
  - `dt_out_valid` takes priority over a same-cycle pass completion or timeout; only `vec_done` pulses.
- **Spurious completion.** `dt_out_valid` in IDLE is ignored for data and sets `err_spurious` until reset.
- **Simultaneous events.** A load finishing in the same cycle a buffer is freed is legal; each buffer's full flag is set and cleared independently.
- **Reset mid-operation.** Reset discards all buffered words and any partial load or pass.

## Timing

- Reset values: `s_ready`=0 while `reset` is high, `dt_valid`=0, `dt_sample`=0, `vec_done`=0, `vec_timeout`=0, `err_spurious`=0, FSM=IDLE, all counters 0, all buffers empty.
- `s_ready` is combinational from the full flags (not from `s_valid`) and is 1 from the first cycle after reset deasserts.
- `dt_valid`, `dt_sample`, `vec_done` and `vec_timeout` are registered.
- Load-to-replay latency: last word accepted at the edge of cycle N gives `dt_valid`=1 with feature 0 in cycle N+1.
- Retire latency: `dt_out_valid` sampled at edge N gives `dt_valid`=0 and `vec_done`=1 in cycle N+1. The next pending vector's feature 0 appears in cycle N+2.
- Pass length with `dt_ready` held high: FEATURES cycles plus 1 GAP cycle.

## Configuration

- `DTREE_FEEDER_DOUBLE_BUF_EN` defined:
  - Two buffers in ping-pong. Upstream loads the shadow buffer while the active one replays.
  - `s_ready`=0 only when both buffers are full.
- Not defined:
  - Single buffer. `s_ready`=0 from the last load beat until the vector is retired or timed out.
  - Replay after retire restarts from IDLE.

## Test plan

- **Basic.** FEATURES=3; load 5,17,1023 with `dt_ready`=1 → `dt_sample` 5,17,1023 in consecutive cycles, one GAP cycle, then the same three again. `dt_out_valid` on the second pass → `vec_done` one cycle later, `dt_valid`=0.
- **Stall.** `dt_ready` low for 4 cycles while `ridx`=1 → `dt_valid`=1 and `dt_sample`=17 held for 4 cycles, then 1023 follows.
- **Timeout.** MAX_PASSES=2, no `dt_out_valid` → exactly 2 passes, `vec_timeout` pulses at the second GAP entry, FSM returns to IDLE, `s_ready`=1.
- **Double buffer.** With `DTREE_FEEDER_DOUBLE_BUF_EN`, load A=(1,2,3) then B=(4,5,6) during A's replay → `s_ready` stays 1 through B's load. `dt_out_valid` → B's first word 4 appears 2 cycles later. Without the macro, `s_ready`=0 until A is retired.
- **Spurious.** `dt_out_valid` in IDLE → `err_spurious`=1 and held; no `vec_done`.
- **Reset mid-pass.** Assert `reset` at `ridx`=1 → next cycle `dt_valid`=0, and after release `s_ready`=1 with all buffers empty.
